pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_if.sv | 30 +++
 rtl/pc_gen.sv | 96 +++++++++
 tb/tb_pc_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-PC bundle: redirect requests and stall in, fetch address and status out.
// Latency: none, wiring only.
// Backpressure: the stall signal carried here is the fetch stage's hold request.
interface pc_gen_if;
    logic        stall;
    logic        trap_valid;
    logic [63:0] trap_vector;
    logic        xret_valid;
    logic [63:0] xret_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        pc_misaligned;

    // Upstream side: drives stall and redirect requests, observes the PC.
    modport master (
        output stall, trap_valid, trap_vector, xret_valid, xret_pc,
               redirect_valid, redirect_pc,
        input  pc, pc_valid, flush, pc_misaligned
    );

    // PC generator side.
    modport slave (
        input  stall, trap_valid, trap_vector, xret_valid, xret_pc,
               redirect_valid, redirect_pc,
        output pc, pc_valid, flush, pc_misaligned
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential +4 fetch with trap > xret > redirect steering.
// Latency: accepted target appears on pc one cycle after the accepting edge.
// Backpressure: stall freezes pc; a redirect seen under stall is parked, never dropped.
module pc_gen #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  io_bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic        r_pc_valid;
    logic        r_pc_misaligned;
    logic [63:0] r_pend_pc;
    logic        r_pend_misaligned;

    logic        w_req;
    logic [63:0] w_tgt_raw;
    logic [63:0] w_tgt;
    logic        w_tgt_misaligned;

    // Any redirect source counts as a request; the target follows fixed priority.
    assign w_req            = io_bus.trap_valid | io_bus.xret_valid | io_bus.redirect_valid;
    assign w_tgt_raw        = io_bus.trap_valid ? io_bus.trap_vector :
                              io_bus.xret_valid ? io_bus.xret_pc     :
                                                  io_bus.redirect_pc;
    // Low two bits are dropped on load; the loss is reported via pc_misaligned.
    assign w_tgt            = {w_tgt_raw[63:2], 2'b00};
    assign w_tgt_misaligned = (w_tgt_raw[1:0] != 2'b00);

    // Boot ignores redirects, so flush must stay low there too.
    assign io_bus.flush         = (r_state != BOOT) && (w_req || (r_state == PEND));
    assign io_bus.pc            = r_pc;
    assign io_bus.pc_valid      = r_pc_valid;
    assign io_bus.pc_misaligned = r_pc_misaligned;

    // Control FSM with registered pc, status flags and parked redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= BOOT;
            r_pc              <= RESET_PC;
            r_pc_valid        <= 1'b0;
            r_pc_misaligned   <= 1'b0;
            r_pend_pc         <= 64'd0;
            r_pend_misaligned <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
                RUN: begin
                    if (w_req && !io_bus.stall) begin
                        r_pc            <= w_tgt;
                        r_pc_misaligned <= w_tgt_misaligned;
                        r_pc_valid      <= 1'b1;
                    end else if (w_req) begin
                        r_pend_pc         <= w_tgt;
                        r_pend_misaligned <= w_tgt_misaligned;
                        r_state           <= PEND;
                        r_pc_valid        <= 1'b0;
                    end else if (!io_bus.stall) begin
                        r_pc            <= r_pc + 64'd4;
                        r_pc_misaligned <= 1'b0;
                    end
                end
                PEND: begin
                    if (!io_bus.stall) begin
                        // A newer request wins over the parked one.
                        r_pc            <= w_req ? w_tgt : r_pend_pc;
                        r_pc_misaligned <= w_req ? w_tgt_misaligned : r_pend_misaligned;
                        r_state         <= RUN;
                        r_pc_valid      <= 1'b1;
                    end else if (w_req) begin
                        r_pend_pc         <= w_tgt;
                        r_pend_misaligned <= w_tgt_misaligned;
                    end
                end
                default: begin
                    r_state    <= BOOT;
                    r_pc       <= RESET_PC;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot sequence, priority, stall parking, alignment, wrap, reset.
// Latency: checks sample 1 ns after the rising edge, comparing against hand-computed values.
// Backpressure: stall is driven directly by the directed vectors.
module tb_pc_gen;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    pc_gen_if bus ();

    pc_gen #(.RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        bus.trap_valid     = 1'b0;
        bus.xret_valid     = 1'b0;
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst                = 1'b1;
        bus.stall          = 1'b0;
        bus.trap_valid     = 1'b0;
        bus.trap_vector    = 64'd0;
        bus.xret_valid     = 1'b0;
        bus.xret_pc        = 64'd0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;

        // Reset state
        #12;
        chk("rst_pc",    bus.pc, RST_PC);
        chk("rst_valid", {63'd0, bus.pc_valid}, 64'd0);
        chk("rst_mis",   {63'd0, bus.pc_misaligned}, 64'd0);
        tick();
        rst = 1'b0;
        #1;

        // Boot ignores requests and never flushes
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0000_0000_1234_5670;
        #1;
        chk("boot_flush", {63'd0, bus.flush}, 64'd0);
        chk("boot_valid", {63'd0, bus.pc_valid}, 64'd0);
        clr_req();

        // Boot sequence then sequential fetch
        tick();
        chk("boot_pc",    bus.pc, RST_PC);
        chk("boot_valid1", {63'd0, bus.pc_valid}, 64'd1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", bus.pc, RST_PC + 64'(4 * i));
        end

        // Trap beats redirect
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_8000_0100;
        bus.trap_valid     = 1'b1; bus.trap_vector = 64'h0000_0000_8000_0200;
        #1;
        chk("prio_flush", {63'd0, bus.flush}, 64'd1);
        tick();
        clr_req();
        chk("prio_pc",    bus.pc, 64'h0000_0000_8000_0200);
        chk("prio_valid", {63'd0, bus.pc_valid}, 64'd1);

        // Redirect under stall is parked
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_8000_0040;
        tick();
        clr_req();
        for (int i = 0; i < 4; i++) begin
            chk("pend_pc",    bus.pc, 64'h0000_0000_8000_0200);
            chk("pend_flush", {63'd0, bus.flush}, 64'd1);
            chk("pend_valid", {63'd0, bus.pc_valid}, 64'd0);
            if (i < 3) tick();
        end
        bus.stall = 1'b0;
        tick();
        chk("pend_rel_pc",    bus.pc, 64'h0000_0000_8000_0040);
        chk("pend_rel_flush", {63'd0, bus.flush}, 64'd0);
        chk("pend_rel_valid", {63'd0, bus.pc_valid}, 64'd1);

        // Newer xret overwrites the parked target
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_8000_0040;
        tick();
        clr_req();
        bus.xret_valid = 1'b1; bus.xret_pc = 64'h0000_0000_8000_0300;
        tick();
        clr_req();
        bus.stall = 1'b0;
        tick();
        chk("xret_pc", bus.pc, 64'h0000_0000_8000_0300);

        // Request in PEND with stall low loads directly
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_8000_0500;
        tick();
        clr_req();
        bus.stall = 1'b0;
        bus.trap_valid = 1'b1; bus.trap_vector = 64'h0000_0000_8000_0600;
        tick();
        clr_req();
        chk("pend_direct_pc", bus.pc, 64'h0000_0000_8000_0600);

        // Misaligned target
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_8000_0102;
        tick();
        clr_req();
        chk("mis_pc",  bus.pc, 64'h0000_0000_8000_0100);
        chk("mis_set", {63'd0, bus.pc_misaligned}, 64'd1);
        tick();
        chk("mis_next_pc", bus.pc, 64'h0000_0000_8000_0104);
        chk("mis_clr",     {63'd0, bus.pc_misaligned}, 64'd0);

        // Wrap at top of address space
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        clr_req();
        chk("wrap_top", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_zero", bus.pc, 64'd0);

        // Async reset in PEND discards the parked target
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0000_0000_8000_0700;
        tick();
        clr_req();
        chk("arst_pre_valid", {63'd0, bus.pc_valid}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc",    bus.pc, RST_PC);
        chk("arst_valid", {63'd0, bus.pc_valid}, 64'd0);
        bus.stall = 1'b0;
        #1;
        rst = 1'b0;
        tick();
        chk("arst_boot_pc",    bus.pc, RST_PC);
        chk("arst_boot_valid", {63'd0, bus.pc_valid}, 64'd1);
        tick();
        chk("arst_seq_pc", bus.pc, RST_PC + 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
